// File: rtl/detect_event_logger.sv
// Event logger for the sequence detector: counts detections, measures run length,
// stretches events for a pad and raises an acknowledgeable irq. Optional macro: DETECT_RUNLEN_EN.
module detect_event_logger #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned STRETCH_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             detector_in,
  input  logic             clear,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] last_run,
  output logic             overflow,
  output logic             irq,
  output logic             stretch_out
);

  localparam int unsigned      TMR_W    = $clog2(STRETCH_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic             det_q;
  logic             rise;
  logic             ev_sat;
  logic             run_sat;
  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] next_timer;

  // Edge detection against the one-cycle delayed detector output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) det_q <= 1'b0;
    else       det_q <= detector_in;
  end

  assign rise   = detector_in & ~det_q;
  assign ev_sat = rise & (event_count == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_count <= '0;
    end else if (clear) begin
      event_count <= '0;
    end else if (rise && !ev_sat) begin
      event_count <= event_count + CNT_W'(1);
    end
  end

`ifdef DETECT_RUNLEN_EN
  logic             fall;
  logic             still_high;
  logic [CNT_W-1:0] run_cnt;

  assign fall       = ~detector_in & det_q;
  assign still_high = det_q & detector_in;
  assign run_sat    = still_high & (run_cnt == CNT_MAX);

  // Run length: rise counts as the first high cycle, fall publishes the total
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt  <= '0;
      last_run <= '0;
    end else if (clear) begin
      run_cnt  <= '0;
      last_run <= '0;
    end else begin
      if (rise)                      run_cnt <= CNT_W'(1);
      else if (still_high && !run_sat) run_cnt <= run_cnt + CNT_W'(1);
      if (fall) last_run <= run_cnt;
    end
  end
`else
  assign run_sat  = 1'b0;
  assign last_run = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  overflow <= 1'b0;
    else if (clear)             overflow <= 1'b0;
    else if (ev_sat || run_sat) overflow <= 1'b1;
  end

  // Set beats acknowledge when both land on the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        irq <= 1'b0;
    else if (clear)   irq <= 1'b0;
    else if (rise)    irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      stretch_out <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= next_timer;
      stretch_out <= (next_state == HOLD);
    end
  end

  // Stretch FSM: every rise (re)loads the timer, expiry returns to IDLE
  always_comb begin
    next_state = state;
    next_timer = timer;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = HOLD;
          next_timer = TMR_LOAD;
        end
      end
      HOLD: begin
        if (rise) begin
          next_timer = TMR_LOAD;
        end else if (timer == '0) begin
          next_state = IDLE;
        end else begin
          next_timer = timer - TMR_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_detect_event_logger.sv
// Directed bench for detect_event_logger (CNT_W=4, STRETCH_CYCLES=8); vector table
// plus hand-written sequences for retrigger, saturation, clear and mid-pulse reset.
module tb_detect_event_logger;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STRETCH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             detector_in;
  logic             clear;
  logic             irq_ack;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] last_run;
  logic             overflow;
  logic             irq;
  logic             stretch_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic det;
    logic clr;
    logic ack;
    int   n;
    int   cnt;
    int   lr;
    logic ovf;
    logic irq;
    logic str;
  } vec_t;

  vec_t vecs[12];

  detect_event_logger #(.CNT_W(CNT_W), .STRETCH_CYCLES(STRETCH)) dut (
    .clock(clock),
    .reset(reset),
    .detector_in(detector_in),
    .clear(clear),
    .irq_ack(irq_ack),
    .event_count(event_count),
    .last_run(last_run),
    .overflow(overflow),
    .irq(irq),
    .stretch_out(stretch_out)
  );

  always #5 clock = ~clock;

  function automatic int lrx(input int v);
`ifdef DETECT_RUNLEN_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input int lr,
                           input int ovf, input int irq_e, input int str);
    check({tag, " event_count"}, int'(event_count), cnt);
    check({tag, " last_run"},    int'(last_run),    lr);
    check({tag, " overflow"},    int'(overflow),    ovf);
    check({tag, " irq"},         int'(irq),         irq_e);
    check({tag, " stretch_out"}, int'(stretch_out), str);
  endtask

  initial begin
    int hi;
    // {det, clear, ack, cycles, event_count, last_run, overflow, irq, stretch}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 1, 0,       1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4, 1, 0,       1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1, 1, lrx(5),  1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4, 1, lrx(5),  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 5, 2, lrx(5),  1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5, 2, lrx(5),  1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5, 3, lrx(5),  1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 5, 3, lrx(5),  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1, 3, lrx(5),  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1, 4, lrx(5),  1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1, 4, lrx(1),  1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1, 4, lrx(1),  1'b0, 1'b0, 1'b1};

    reset = 1'b1; detector_in = 1'b0; clear = 1'b0; irq_ack = 1'b0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      detector_in = vecs[i].det;
      clear       = vecs[i].clr;
      irq_ack     = vecs[i].ack;
      repeat (vecs[i].n) tick();
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].lr,
                int'(vecs[i].ovf), int'(vecs[i].irq), int'(vecs[i].str));
    end
    detector_in = 1'b0; clear = 1'b0; irq_ack = 1'b0;

    // Single 1-cycle pulse stretches to exactly STRETCH cycles
    repeat (10) tick();
    check("idle stretch_out", int'(stretch_out), 0);
    detector_in = 1'b1; tick(); hi = int'(stretch_out);
    detector_in = 1'b0;
    repeat (19) begin tick(); hi += int'(stretch_out); end
    check("single pulse stretch length", hi, 8);

    // Retrigger four cycles after the first rise
    detector_in = 1'b1; tick(); hi = int'(stretch_out);
    detector_in = 1'b0;
    repeat (3) begin tick(); hi += int'(stretch_out); end
    detector_in = 1'b1; tick(); hi += int'(stretch_out);
    detector_in = 1'b0;
    repeat (20) begin tick(); hi += int'(stretch_out); end
    check("retrigger stretch length", hi, 12);
    check("retrigger event_count", int'(event_count), 7);

    clear = 1'b1; tick(); clear = 1'b0;
    check_all("clear", 0, 0, 0, 0, 0);

    // Event counter saturation at 15
    for (int i = 0; i < 15; i++) begin
      detector_in = 1'b1; tick();
      detector_in = 1'b0; tick();
    end
    check("15 pulses event_count", int'(event_count), 15);
    check("15 pulses overflow", int'(overflow), 0);
    detector_in = 1'b1; tick();
    detector_in = 1'b0; tick();
    check("16 pulses event_count", int'(event_count), 15);
    check("16 pulses overflow", int'(overflow), 1);
    check("16 pulses irq", int'(irq), 1);

    // Clear wins over a same-cycle rise
    detector_in = 1'b1; clear = 1'b1; tick();
    clear = 1'b0;
    check("clear+rise event_count", int'(event_count), 0);
    check("clear+rise overflow", int'(overflow), 0);
    check("clear+rise irq", int'(irq), 0);
    detector_in = 1'b0; tick();

    // Long run saturates the run counter
    detector_in = 1'b1;
    repeat (20) tick();
    detector_in = 1'b0; tick();
    check("long run last_run", int'(last_run), lrx(15));
    check("long run overflow", int'(overflow), lrx(1));
    check("long run event_count", int'(event_count), 1);

    // Reset in the middle of a held detection
    detector_in = 1'b1;
    repeat (3) tick();
    check("pre-reset event_count", int'(event_count), 2);
    reset = 1'b1; #1;
    check_all("async reset", 0, 0, 0, 0, 0);
    tick();
    check_all("held reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    check("post-reset event_count", int'(event_count), 1);
    check("post-reset irq", int'(irq), 1);
    check("post-reset stretch_out", int'(stretch_out), 1);
    detector_in = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
